// File: rtl/retire_ctrl_pkg.sv
// Shared types for the in-order commit path: ROB head entry layout,
// retire FSM states and widths of physical registers and PCs.
package retire_ctrl_pkg;

    localparam int PR     = 6;
    localparam int XLEN   = 32;
    localparam int AREG_W = 5;
    localparam int WAYS   = 3;

    typedef struct packed {
        logic              valid;
        logic              completed;
        logic              precise_state_need;
        logic              halt;
        logic [AREG_W-1:0] arch_reg;
        logic [PR-1:0]     Tnew;
        logic [PR-1:0]     Told;
        logic [XLEN-1:0]   target_pc;
    } ROB_ENTRY_PACKET;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        RECOVER = 2'd1,
        HALTED  = 2'd2
    } RETIRE_STATE;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/retire_ctrl_if.sv
// ROB-facing commit bus: head entries in, retire acknowledge and the
// registered map-table / free-list updates out.
interface retire_ctrl_if;
    import retire_ctrl_pkg::*;

    ROB_ENTRY_PACKET [2:0]             rob_head_entry;
    logic            [2:0]             retire_ack;
    logic            [2:0]             arch_update_valid;
    logic            [2:0][AREG_W-1:0] arch_update_reg;
    logic            [2:0][PR-1:0]     arch_update_pr;
    logic            [2:0]             free_valid;
    logic            [2:0][PR-1:0]     free_pr;

    // Commit controller side
    modport master (
        input  rob_head_entry,
        output retire_ack,
        output arch_update_valid,
        output arch_update_reg,
        output arch_update_pr,
        output free_valid,
        output free_pr
    );

    // ROB / rename side
    modport slave (
        output rob_head_entry,
        input  retire_ack,
        input  arch_update_valid,
        input  arch_update_reg,
        input  arch_update_pr,
        input  free_valid,
        input  free_pr
    );

endinterface

// File: rtl/retire_ctrl_select.sv
// Combinational retire-group selection over the three oldest ROB entries
// (way 2 oldest); yields a thermometer ack plus one-hot mispredict/halt ways.
module retire_ctrl_select
    import retire_ctrl_pkg::*;
(
    input  RETIRE_STATE state,
    input  logic [2:0]  valid,
    input  logic [2:0]  completed,
    input  logic [2:0]  precise_state_need,
    input  logic [2:0]  halt_flag,
    output logic [2:0]  ack,
    output logic [2:0]  mispredict_way,
    output logic [2:0]  halt_way
);

    logic open;

    // A precise-state or halt entry closes the group after itself retires.
    always_comb begin
        ack            = '0;
        mispredict_way = '0;
        halt_way       = '0;
        open           = (state == NORMAL);
        for (int i = 2; i >= 0; i--) begin
            ack[i]            = open & valid[i] & completed[i];
            halt_way[i]       = ack[i] & halt_flag[i];
            mispredict_way[i] = ack[i] & precise_state_need[i] & ~halt_flag[i];
            open              = ack[i] & ~precise_state_need[i] & ~halt_flag[i];
        end
    end

endmodule

// File: rtl/retire_ctrl.sv
// In-order commit controller for the 3-way ROB: retire selection, recovery
// and halt sequencing, and the registered architectural/free-list updates.
module retire_ctrl
    import retire_ctrl_pkg::*;
#(
    parameter int RECOVER_CYCLES = 2
) (
    input  logic            clock,
    input  logic            reset,
    retire_ctrl_if.master   rif,
    output logic            BPRecoverEN,
    output logic [XLEN-1:0] recover_pc,
    output logic            fetch_stall,
    output logic            halt,
    output logic [31:0]     instr_count
);

    localparam int CNT_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RECOVER_CYCLES - 1);

    RETIRE_STATE      state_r, state_nxt;
    logic [CNT_W-1:0] cnt_r, cnt_nxt;

    logic [2:0]       hv, hc, hpsn, hhalt;
    logic [2:0]       ack_c, mp_way_c, halt_way_c;
    logic [XLEN-1:0]  mp_pc_c;

    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            hv[i]    = rif.rob_head_entry[i].valid;
            hc[i]    = rif.rob_head_entry[i].completed;
            hpsn[i]  = rif.rob_head_entry[i].precise_state_need;
            hhalt[i] = rif.rob_head_entry[i].halt;
        end
    end

    retire_ctrl_select u_select (
        .state              (state_r),
        .valid              (hv),
        .completed          (hc),
        .precise_state_need (hpsn),
        .halt_flag          (hhalt),
        .ack                (ack_c),
        .mispredict_way     (mp_way_c),
        .halt_way           (halt_way_c)
    );

    assign rif.retire_ack = ack_c;
    assign fetch_stall    = (state_r == RECOVER);

    always_comb begin
        mp_pc_c = '0;
        for (int i = 0; i < WAYS; i++) begin
            mp_pc_c = mp_pc_c | ({XLEN{mp_way_c[i]}} & rif.rob_head_entry[i].target_pc);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= NORMAL;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
        end
    end

    // cnt counts the remaining stall cycles after the current one.
    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        unique case (state_r)
            NORMAL: begin
                if (|halt_way_c) begin
                    state_nxt = HALTED;
                end else if (|mp_way_c) begin
                    state_nxt = RECOVER;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            RECOVER: begin
                if (cnt_r == '0) begin
                    state_nxt = NORMAL;
                end else begin
                    cnt_nxt = cnt_r - CNT_W'(1);
                end
            end
            HALTED: begin
                state_nxt = HALTED;
            end
            default: begin
                state_nxt = NORMAL;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Commit stage boundary: everything acked this cycle is published next cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rif.arch_update_valid <= '0;
            rif.arch_update_reg   <= '0;
            rif.arch_update_pr    <= '0;
            rif.free_valid        <= '0;
            rif.free_pr           <= '0;
            BPRecoverEN           <= 1'b0;
            recover_pc            <= '0;
            halt                  <= 1'b0;
            instr_count           <= '0;
        end else begin
            for (int i = 0; i < WAYS; i++) begin
                rif.arch_update_valid[i] <= ack_c[i] && (rif.rob_head_entry[i].arch_reg != '0);
                rif.free_valid[i]        <= ack_c[i] && (rif.rob_head_entry[i].arch_reg != '0);
                rif.arch_update_reg[i]   <= ack_c[i] ? rif.rob_head_entry[i].arch_reg : '0;
                rif.arch_update_pr[i]    <= ack_c[i] ? rif.rob_head_entry[i].Tnew : '0;
                rif.free_pr[i]           <= ack_c[i] ? rif.rob_head_entry[i].Told : '0;
            end
            BPRecoverEN <= |mp_way_c;
            if (|mp_way_c) begin
                recover_pc <= mp_pc_c;
            end
            halt        <= halt | (|halt_way_c);
            instr_count <= instr_count + 32'(popcount3(ack_c));
        end
    end

endmodule

// File: tb/tb_retire_ctrl.sv
// Scoreboard bench for retire_ctrl: stimulus pushes expected responses from a
// rule-level commit model; a negedge monitor pops and compares.
module tb_retire_ctrl;
    import retire_ctrl_pkg::*;

    localparam int RC = 2;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            bp;
    logic [XLEN-1:0] rpc;
    logic            stall;
    logic            halt_o;
    logic [31:0]     icount;

    always #5 clock = ~clock;

    retire_ctrl_if rif();

    retire_ctrl #(.RECOVER_CYCLES(RC)) dut (
        .clock       (clock),
        .reset       (reset),
        .rif         (rif.master),
        .BPRecoverEN (bp),
        .recover_pc  (rpc),
        .fetch_stall (stall),
        .halt        (halt_o),
        .instr_count (icount)
    );

    typedef struct {
        logic [2:0]             ack;
        logic                   stall;
        logic [2:0]             uv;
        logic [2:0][AREG_W-1:0] ureg;
        logic [2:0][PR-1:0]     upr;
        logic [2:0][PR-1:0]     fpr;
        logic                   bp;
        logic [XLEN-1:0]        pc;
        logic                   halt;
        logic [31:0]            cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_reg;
    int   m_mode;   // 0 normal, 1 stalled for recovery, 2 halted
    int   m_left;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic ROB_ENTRY_PACKET mk(input logic v, input logic c, input logic psn,
                                           input logic h, input int areg, input int tnew,
                                           input int told, input logic [XLEN-1:0] pc);
        ROB_ENTRY_PACKET e;
        e.valid              = v;
        e.completed          = c;
        e.precise_state_need = psn;
        e.halt               = h;
        e.arch_reg           = AREG_W'(areg);
        e.Tnew               = PR'(tnew);
        e.Told               = PR'(told);
        e.target_pc          = pc;
        return e;
    endfunction

    function automatic ROB_ENTRY_PACKET rnd(input int psn_pct, input int halt_pct);
        return mk(($urandom % 8) != 0, ($urandom % 4) != 0,
                  int'($urandom % 100) < psn_pct, int'($urandom % 100) < halt_pct,
                  int'($urandom % 32), int'($urandom % 64), int'($urandom % 64), $urandom);
    endfunction

    // One cycle: drive heads, record what the DUT must show now, advance the model.
    task automatic drive_cycle(input ROB_ENTRY_PACKET [2:0] e);
        exp_t       x;
        logic [2:0] a;
        int         hh;
        int         mp;
        @(posedge clock);
        #2;
        rif.rob_head_entry = e;
        a  = '0;
        hh = -1;
        mp = -1;
        if (m_mode == 0) begin
            for (int i = 2; i >= 0; i--) begin
                if (!(e[i].valid && e[i].completed)) break;
                a[i] = 1'b1;
                if (e[i].halt) begin hh = i; break; end
                if (e[i].precise_state_need) begin mp = i; break; end
            end
        end
        x       = m_reg;
        x.ack   = a;
        x.stall = (m_mode == 1);
        exp_q.push_back(x);

        for (int i = 0; i < 3; i++) begin
            m_reg.uv[i]   = a[i] && (e[i].arch_reg != 0);
            m_reg.ureg[i] = a[i] ? e[i].arch_reg : '0;
            m_reg.upr[i]  = a[i] ? e[i].Tnew : '0;
            m_reg.fpr[i]  = a[i] ? e[i].Told : '0;
        end
        m_reg.bp = (mp >= 0);
        if (mp >= 0) m_reg.pc = e[mp].target_pc;
        if (hh >= 0) m_reg.halt = 1'b1;
        m_reg.cnt = m_reg.cnt + 32'(a[0]) + 32'(a[1]) + 32'(a[2]);

        if (m_mode == 0) begin
            if (hh >= 0) m_mode = 2;
            else if (mp >= 0) begin m_mode = 1; m_left = RC; end
        end else if (m_mode == 1) begin
            m_left--;
            if (m_left == 0) m_mode = 0;
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_left = 0;
        m_reg  = '{default: '0};
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ack"},   64'(rif.retire_ack), 0);
        chk({tag, "_uv"},    64'(rif.arch_update_valid), 0);
        chk({tag, "_fv"},    64'(rif.free_valid), 0);
        chk({tag, "_bp"},    64'(bp), 0);
        chk({tag, "_pc"},    64'(rpc), 0);
        chk({tag, "_stall"}, 64'(stall), 0);
        chk({tag, "_halt"},  64'(halt_o), 0);
        chk({tag, "_count"}, 64'(icount), 0);
    endtask

    // Asynchronous reset asserted mid-cycle while the model sits in recovery.
    task automatic async_reset_mid_recover();
        @(posedge clock);
        #3;
        chk("pre_rst_stall", 64'(stall), 1);
        chk("pre_rst_bp", 64'(bp), 1);
        rif.rob_head_entry = '0;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(posedge clock);
        #2;
        reset = 1'b1;
    endtask

    always @(negedge clock) begin
        exp_t x;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("retire_ack", 64'(rif.retire_ack), 64'(x.ack));
            chk("fetch_stall", 64'(stall), 64'(x.stall));
            chk("arch_update_valid", 64'(rif.arch_update_valid), 64'(x.uv));
            chk("free_valid", 64'(rif.free_valid), 64'(x.uv));
            for (int i = 0; i < 3; i++) begin
                if (x.uv[i]) begin
                    chk($sformatf("arch_update_reg[%0d]", i), 64'(rif.arch_update_reg[i]), 64'(x.ureg[i]));
                    chk($sformatf("arch_update_pr[%0d]", i), 64'(rif.arch_update_pr[i]), 64'(x.upr[i]));
                    chk($sformatf("free_pr[%0d]", i), 64'(rif.free_pr[i]), 64'(x.fpr[i]));
                end
            end
            chk("BPRecoverEN", 64'(bp), 64'(x.bp));
            if (x.bp) chk("recover_pc", 64'(rpc), 64'(x.pc));
            chk("halt", 64'(halt_o), 64'(x.halt));
            chk("instr_count", 64'(icount), 64'(x.cnt));
        end
    end

    initial begin
        ROB_ENTRY_PACKET [2:0] e;
        rif.rob_head_entry = '0;
        model_reset();
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b1;

        e = '0;
        repeat (2) drive_cycle(e);

        // Full retire
        e[2] = mk(1, 1, 0, 0, 1, 32, 1, 0);
        e[1] = mk(1, 1, 0, 0, 2, 33, 2, 0);
        e[0] = mk(1, 1, 0, 0, 3, 34, 3, 0);
        drive_cycle(e);

        // Partial retire: way 1 still executing
        e[2] = mk(1, 1, 0, 0, 4, 40, 14, 0);
        e[1] = mk(1, 0, 0, 0, 5, 41, 15, 0);
        e[0] = mk(1, 1, 0, 0, 6, 42, 16, 0);
        drive_cycle(e);
        e[2] = e[1];
        e[1] = e[0];
        e[0] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        drive_cycle(e);
        e[2].completed = 1'b1;
        drive_cycle(e);

        // Mispredict on way 1, then stalled completed heads, then resume
        e[2] = mk(1, 1, 0, 0, 7, 50, 20, 0);
        e[1] = mk(1, 1, 1, 0, 8, 51, 21, 32);
        e[0] = mk(1, 1, 0, 0, 9, 52, 22, 0);
        drive_cycle(e);
        e[2] = mk(1, 1, 0, 0, 10, 53, 23, 0);
        e[1] = mk(1, 1, 0, 0, 11, 54, 24, 0);
        e[0] = mk(1, 1, 0, 0, 12, 55, 25, 0);
        repeat (RC + 1) drive_cycle(e);

        // Architectural register 0 retires without update or free
        e[2] = mk(1, 1, 0, 0, 0, 60, 30, 0);
        e[1] = mk(1, 1, 0, 0, 13, 61, 31, 0);
        e[0] = mk(1, 1, 0, 0, 0, 62, 32, 0);
        drive_cycle(e);

        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 3; i++) e[i] = rnd(10, 0);
            drive_cycle(e);
        end

        // Reset while recovering
        e[2] = mk(1, 1, 1, 0, 14, 63, 33, 32'h100);
        e[1] = mk(1, 1, 0, 0, 15, 1, 2, 0);
        e[0] = mk(1, 1, 0, 0, 16, 3, 4, 0);
        drive_cycle(e);
        async_reset_mid_recover();

        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < 3; i++) e[i] = rnd(10, 0);
            drive_cycle(e);
        end

        // Halt carrying precise_state_need: halt wins, nothing retires afterwards
        e[2] = mk(1, 1, 1, 1, 17, 5, 6, 32'h200);
        e[1] = mk(1, 1, 0, 0, 18, 7, 8, 0);
        e[0] = mk(1, 1, 0, 0, 19, 9, 10, 0);
        drive_cycle(e);
        e[2] = mk(1, 1, 0, 0, 20, 11, 12, 0);
        e[1] = mk(1, 1, 1, 0, 21, 13, 14, 32'h300);
        e[0] = mk(1, 1, 0, 0, 22, 15, 16, 0);
        repeat (5) drive_cycle(e);
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 3; i++) e[i] = rnd(20, 5);
            drive_cycle(e);
        end

        repeat (2) @(negedge clock);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/retire_ctrl.md
# retire_ctrl

- In-order commit controller for the 3-way ROB.
- Every cycle it examines the three oldest ROB entries and decides how many retire, acknowledging them to the ROB in the same cycle.
- One cycle later it drives the architectural map-table updates and the free-list releases for those entries.
- It sequences branch-mispredict recovery (BPRecoverEN plus a stall window) and the terminal halt.

## Interface
- RECOVER_CYCLES, 2: cycles fetch_stall is held, counted from the BPRecoverEN cycle; legal values ≥1.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; block is in reset while 0.
- rob_head_entry  in  ROB_ENTRY_PACKET[2:0]  three oldest ROB entries; [2] oldest, [0] youngest.
- retire_ack  out  [2:0]  combinational; entries consumed this cycle; the ROB advances head by popcount.
- arch_update_valid  out  [2:0]  registered; map-table write enables.
- arch_update_reg  out  [2:0][4:0]  registered; destination architectural register.
- arch_update_pr  out  [2:0][`PR-1:0]  registered; Tnew of the retired entry.
- free_valid  out  [2:0]  registered; free-list push enables.
- free_pr  out  [2:0][`PR-1:0]  registered; Told of the retired entry.
- BPRecoverEN  out  1  registered one-cycle pulse; flushes the ROB, RS and fetch.
- recover_pc  out  [`XLEN-1:0]  registered; target_pc of the mispredicted entry, valid with BPRecoverEN.
- fetch_stall  out  1  high throughout RECOVER.
- halt  out  1  sticky once a halt entry retires.
- instr_count  out  [31:0]  retired-instruction counter.

## Operation
- **FSM states:** NORMAL, RECOVER, HALTED. Reset state is NORMAL.
- **Retire rule (NORMAL only):** way i retires when all of the following hold:
  - valid and completed;
  - every older way also retires;
  - no older way has precise_state_need=1 or halt=1.
  - retire_ack is therefore a thermometer code: 000, 100, 110 or 111.
  - An entry carrying precise_state_need or halt terminates the group, inclusive.
- **Per retired way, registered:**
  - arch_update_valid = free_valid = (arch_reg != 0).
  - arch_update_reg = arch_reg, arch_update_pr = Tnew, free_pr = Told.
  - Entries with arch_reg 0 retire but produce no update and no free.
- **Mispredict:** a retired entry with precise_state_need=1 and halt=0 causes:
  - next state RECOVER;
  - BPRecoverEN=1 for exactly one cycle;
  - recover_pc = its target_pc;
  - cnt loaded with RECOVER_CYCLES-1.
- **RECOVER:**
  - retire_ack=000 and fetch_stall=1.
  - cnt decrements each cycle.
  - When cnt==0, next state is NORMAL.
- **Halt:** a retired entry with halt=1 causes next state HALTED and halt=1; halt takes precedence over precise_state_need.
- **HALTED:**
  - retire_ack=000 permanently, halt stays 1, no further BPRecoverEN.
  - Only reset exits this state.
- **instr_count:** adds popcount(retire_ack) in the following cycle; 32-bit, wraps modulo 2^32.
- **Invalid head entries** (valid=0, e.g. ROB empty): never retire, no effect.

## Timing
- **Reset values:**
  - state NORMAL, cnt 0.
  - retire_ack 0, all arch/free valids and data 0.
  - BPRecoverEN 0, recover_pc 0, fetch_stall 0, halt 0, instr_count 0.
- **Retire decision:** retire_ack has zero-cycle latency. Updates, frees, BPRecoverEN, halt and instr_count have one-cycle latency.
- **Mispredict sequence** (branch retires at cycle T):
  - T+1: BPRecoverEN and fetch_stall high.
  - fetch_stall stays high through T+RECOVER_CYCLES.
  - Earliest next retire is T+RECOVER_CYCLES+1.
- **Same-group retires:** entries older than the branch in the same group are committed alongside it in T+1. Younger entries in that group are never retired; they are flushed.
- **Reset mid-RECOVER or in HALTED:** returns to NORMAL immediately. Outputs clear asynchronously.

## Structure
- **Shared sys_defs package:**
  - ROB_ENTRY_PACKET (existing);
  - new RETIRE_STATE enum {NORMAL, RECOVER, HALTED};
  - `PR and `XLEN.
- **Sub-module:** retire_select, purely combinational. It maps head entries and state to retire_ack, mispredict way, and halt way.
- **Top level (retire_ctrl):** holds the FSM, the counter, and the output registers.

## Test plan
- **Full retire:** three valid, completed head entries with arch_reg 1/2/3, Tnew 32/33/34, Told 1/2/3 → retire_ack=111. Next cycle:
  - arch_update_valid=111 with pr 32/33/34;
  - free_pr 1/2/3;
  - instr_count=3.
- **Partial retire:** way[2] completed, way[1] not, way[0] completed → retire_ack=100. Way[0] is not retired until way[1] completes.
- **Mispredict, RECOVER_CYCLES=2:** way[1] has precise_state_need=1, target_pc=32, and all three ways are completed →
  - retire_ack=110;
  - at T+1, BPRecoverEN=1 for one cycle and recover_pc=32;
  - fetch_stall high at T+1 and T+2;
  - retire resumes at T+3.
- **Halt:** way[2] carries halt=1 and precise_state_need=1 →
  - retire_ack=100, halt=1, BPRecoverEN stays 0;
  - completed entries presented afterward are never acked.
- **arch_reg 0:** retiring an entry with arch_reg 0 → retire_ack set, but arch_update_valid and free_valid are 0 for that way.
- **Asynchronous reset during RECOVER:** reset driven to 0 between clock edges → fetch_stall, BPRecoverEN and instr_count clear immediately, and state returns to NORMAL.
